// File: rtl/sprite_fetch_ctrl_pkg.sv
// Shared PPU definitions for the sprite fetch path: slot count, sequencer
// state encoding and the per-sprite attribute bundle layout.
package sprite_fetch_ctrl_pkg;

    localparam int unsigned NSLOTS = 10;
    localparam int unsigned SLOT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        RENDER,
        FETCH_LO,
        FETCH_HI,
        SAVE
    } fetch_state_t;

    // Attribute bundle as delivered by the OAM scanner: {prio, pal, cgb_pal}.
    typedef struct packed {
        logic       prio;
        logic       pal;
        logic [2:0] cgb_pal;
    } spr_attr_t;

endpackage

// File: rtl/sprite_fetch_ctrl_if.sv
// VRAM read channel between the sprite fetch sequencer and the VRAM arbiter.
//   vram_req   : read request, held until vram_ack
//   vram_plane : 0 = low tile plane, 1 = high tile plane
//   vram_slot  : sprite slot being fetched (address is formed by the arbiter)
//   vram_ack   : read data valid this cycle
//   vram_data  : read data
// master = sequencer side, slave = arbiter side.
interface sprite_fetch_ctrl_if;
    import sprite_fetch_ctrl_pkg::*;

    logic              vram_req;
    logic              vram_plane;
    logic [SLOT_W-1:0] vram_slot;
    logic              vram_ack;
    logic [7:0]        vram_data;

    modport master (
        output vram_req,
        output vram_plane,
        output vram_slot,
        input  vram_ack,
        input  vram_data
    );

    modport slave (
        input  vram_req,
        input  vram_plane,
        input  vram_slot,
        output vram_ack,
        output vram_data
    );

endinterface

// File: rtl/sprite_fetch_ctrl_lowest_bit_sel.sv
// Priority encoder: index of the lowest set bit of vec, plus an any-set flag.
// Ports:
//   vec : request vector (N bits)
//   idx : index of the lowest set bit (0 when vec is empty)
//   any : 1 when any bit of vec is set
// Shared with the sprite pixel mixer, where the lowest slot also wins.
module sprite_fetch_ctrl_lowest_bit_sel #(
    parameter int unsigned N  = 10,
    parameter int unsigned IW = 4
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        idx = '0;
        any = |vec;
        // Scan downwards so the last hit written is the lowest index.
        for (int unsigned i = N; i > 0; i--) begin
            if (vec[i-1]) begin
                idx = IW'(i - 1);
            end
        end
    end

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Per-scanline sprite fetch sequencer.
// Allocates scanned sprites to the sprite extra stores in scan order, then
// during rendering stalls the background pipeline and fetches both tile
// planes from VRAM for every store whose X matches, writing them back.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   ce                : clock enable for all state
//   line_start        : starts (or aborts and restarts) a scanline
//   oam_valid/oam_x/oam_attr/scan_done : OAM scanner results
//   render_x, x_match_vec              : pixel X and store match lines
//   store_reset, store_xpos, save_x_vec, tile_save_vec : store control
//   tile0_o, tile1_o, index_o, pal_o, prio_o, cgb_pal_o : store write data
//   vram              : VRAM read channel (master modport)
//   bg_stall          : hold background fetcher / pixel shifter
//   overflow          : a sprite beyond NSLOTS was dropped this line
module sprite_fetch_ctrl #(
    parameter int unsigned NSLOTS = sprite_fetch_ctrl_pkg::NSLOTS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ce,
    input  logic                line_start,
    input  logic                oam_valid,
    input  logic [7:0]          oam_x,
    input  logic [4:0]          oam_attr,
    input  logic                scan_done,
    input  logic [7:0]          render_x,
    input  logic [NSLOTS-1:0]   x_match_vec,
    output logic                store_reset,
    output logic [7:0]          store_xpos,
    output logic [NSLOTS-1:0]   save_x_vec,
    output logic [NSLOTS-1:0]   tile_save_vec,
    output logic [7:0]          tile0_o,
    output logic [7:0]          tile1_o,
    output logic [3:0]          index_o,
    output logic                pal_o,
    output logic                prio_o,
    output logic [2:0]          cgb_pal_o,
    sprite_fetch_ctrl_if.master vram,
    output logic                bg_stall,
    output logic                overflow
);
    import sprite_fetch_ctrl_pkg::*;

    fetch_state_t      state;
    logic [SLOT_W-1:0] count;
    logic [NSLOTS-1:0] valid_q;
    logic [NSLOTS-1:0] fetched_q;
    spr_attr_t         attr_q [NSLOTS];
    logic [SLOT_W-1:0] slot_q;
    logic              req_q;
    logic              plane_q;
    logic [7:0]        tile0_q;
    logic [7:0]        tile1_q;
    logic [SLOT_W-1:0] index_q;
    spr_attr_t         attr_o_q;
    logic              overflow_q;

    logic [NSLOTS-1:0] pending;
    logic [SLOT_W-1:0] sel;
    logic              pend_any;
    logic              alloc_ok;
    spr_attr_t         slot_attr;

    assign pending  = x_match_vec & valid_q & ~fetched_q;
    assign alloc_ok = 32'(count) < NSLOTS;

    sprite_fetch_ctrl_lowest_bit_sel #(
        .N  (NSLOTS),
        .IW (SLOT_W)
    ) u_sel (
        .vec (pending),
        .idx (sel),
        .any (pend_any)
    );

    always_comb begin
        store_reset   = ce & line_start;
        store_xpos    = (state == SCAN) ? oam_x : render_x;
        save_x_vec    = '0;
        tile_save_vec = '0;
        slot_attr     = '0;
        for (int unsigned i = 0; i < NSLOTS; i++) begin
            // A line_start in the same cycle aborts the line, so it masks
            // both strobes even though the state has not moved yet.
            if (ce && !line_start && state == SCAN && oam_valid && 32'(count) == i) begin
                save_x_vec[i] = 1'b1;
            end
            if (ce && !line_start && state == SAVE && 32'(index_q) == i) begin
                tile_save_vec[i] = 1'b1;
            end
            if (32'(slot_q) == i) begin
                slot_attr = attr_q[i];
            end
        end
        bg_stall = ((state == RENDER) && pend_any) ||
                   (state == FETCH_LO) || (state == FETCH_HI) || (state == SAVE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            valid_q    <= '0;
            fetched_q  <= '0;
            for (int unsigned i = 0; i < NSLOTS; i++) begin
                attr_q[i] <= '0;
            end
            slot_q     <= '0;
            req_q      <= 1'b0;
            plane_q    <= 1'b0;
            tile0_q    <= '0;
            tile1_q    <= '0;
            index_q    <= '0;
            attr_o_q   <= '0;
            overflow_q <= 1'b0;
        end else if (ce) begin
            if (line_start) begin
                state      <= SCAN;
                count      <= '0;
                valid_q    <= '0;
                fetched_q  <= '0;
                req_q      <= 1'b0;
                plane_q    <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    SCAN: begin
                        if (oam_valid) begin
                            if (alloc_ok) begin
                                for (int unsigned i = 0; i < NSLOTS; i++) begin
                                    if (32'(count) == i) begin
                                        attr_q[i]  <= spr_attr_t'(oam_attr);
                                        valid_q[i] <= 1'b1;
                                    end
                                end
                                count <= count + SLOT_W'(1);
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end
                        if (scan_done) begin
                            state <= RENDER;
                        end
                    end
                    RENDER: begin
                        if (pend_any) begin
                            state   <= FETCH_LO;
                            slot_q  <= sel;
                            req_q   <= 1'b1;
                            plane_q <= 1'b0;
                        end
                    end
                    FETCH_LO: begin
                        if (vram.vram_ack) begin
                            tile0_q <= vram.vram_data;
                            plane_q <= 1'b1;
                            state   <= FETCH_HI;
                        end
                    end
                    FETCH_HI: begin
                        if (vram.vram_ack) begin
                            tile1_q  <= vram.vram_data;
                            index_q  <= slot_q;
                            attr_o_q <= slot_attr;
                            req_q    <= 1'b0;
                            plane_q  <= 1'b0;
                            state    <= SAVE;
                        end
                    end
                    SAVE: begin
                        for (int unsigned i = 0; i < NSLOTS; i++) begin
                            if (32'(index_q) == i) begin
                                fetched_q[i] <= 1'b1;
                            end
                        end
                        state <= RENDER;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign vram.vram_req   = req_q;
    assign vram.vram_plane = plane_q;
    assign vram.vram_slot  = slot_q;
    assign tile0_o         = tile0_q;
    assign tile1_o         = tile1_q;
    assign index_o         = index_q;
    assign prio_o          = attr_o_q.prio;
    assign pal_o           = attr_o_q.pal;
    assign cgb_pal_o       = attr_o_q.cgb_pal;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Self-checking bench for sprite_fetch_ctrl. A scanline is described by a
// list of sprites (X, attr); the expected allocation, fetch order (ascending
// slot among allocated sprites whose X equals render_x), fetch durations and
// written data are derived from that list.
module tb_sprite_fetch_ctrl;

    localparam int NS = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ce;
    logic          line_start;
    logic          oam_valid;
    logic [7:0]    oam_x;
    logic [4:0]    oam_attr;
    logic          scan_done;
    logic [7:0]    render_x;
    logic [NS-1:0] x_match_vec;
    logic          store_reset;
    logic [7:0]    store_xpos;
    logic [NS-1:0] save_x_vec;
    logic [NS-1:0] tile_save_vec;
    logic [7:0]    tile0_o;
    logic [7:0]    tile1_o;
    logic [3:0]    index_o;
    logic          pal_o;
    logic          prio_o;
    logic [2:0]    cgb_pal_o;
    logic          bg_stall;
    logic          overflow;

    sprite_fetch_ctrl_if vif();

    sprite_fetch_ctrl #(.NSLOTS(NS)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ce            (ce),
        .line_start    (line_start),
        .oam_valid     (oam_valid),
        .oam_x         (oam_x),
        .oam_attr      (oam_attr),
        .scan_done     (scan_done),
        .render_x      (render_x),
        .x_match_vec   (x_match_vec),
        .store_reset   (store_reset),
        .store_xpos    (store_xpos),
        .save_x_vec    (save_x_vec),
        .tile_save_vec (tile_save_vec),
        .tile0_o       (tile0_o),
        .tile1_o       (tile1_o),
        .index_o       (index_o),
        .pal_o         (pal_o),
        .prio_o        (prio_o),
        .cgb_pal_o     (cgb_pal_o),
        .vram          (vif),
        .bg_stall      (bg_stall),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int         n_spr;
    logic [7:0] spr_x    [12];
    logic [4:0] spr_attr [12];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1);
    end

    task automatic quiet_inputs();
        line_start    = 1'b0;
        oam_valid     = 1'b0;
        oam_x         = '0;
        oam_attr      = '0;
        scan_done     = 1'b0;
        x_match_vec   = '0;
        vif.vram_ack  = 1'b0;
        vif.vram_data = '0;
    endtask

    // One scanline: line_start, scan of spr_x/spr_attr, then each distinct
    // allocated X rendered in turn with a latency-lat VRAM responder.
    task automatic run_line(input int lat, input bit ce_alt, input bit abort_hi, input bit fixed_data);
        logic [NS-1:0] one;
        logic [NS-1:0] exp_vec;
        logic [7:0]    xs[$];
        int            fetch_q[$];
        int            nalloc;
        int            wait_cnt;
        int            ce_idx;
        int            first_req;
        bit            cur_ce;
        bit            lo_done;
        bit            seen;
        logic [7:0]    lo_val;
        logic [7:0]    hi_val;
        logic [7:0]    rx;
        int            nf;
        int            s;

        one = 1;
        lo_val = '0;
        hi_val = '0;
        nalloc = (n_spr < NS) ? n_spr : NS;

        @(negedge clk);
        quiet_inputs();
        if (ce_alt) begin
            ce = 1'b0;
            line_start = 1'b1;
            #1;
            n_tests++;
            if (store_reset !== 1'b0) begin
                n_fail++;
                $display("FAIL store_reset_ce0: got %b want 0", store_reset);
            end
            @(negedge clk);
        end
        ce = 1'b1;
        line_start = 1'b1;
        #1;
        n_tests++;
        if (store_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL store_reset_pulse: got %b want 1", store_reset);
        end
        @(negedge clk);
        line_start = 1'b0;
        #1;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_cleared: got %b want 0", overflow);
        end

        // Scan phase; the last sprite arrives together with scan_done.
        for (int k = 0; k < n_spr; k++) begin
            oam_valid = 1'b1;
            oam_x     = spr_x[k];
            oam_attr  = spr_attr[k];
            scan_done = (k == n_spr - 1);
            if (ce_alt) begin
                ce = 1'b0;
                #1;
                n_tests++;
                if (save_x_vec !== '0) begin
                    n_fail++;
                    $display("FAIL save_x_ce0: got %h want 0", save_x_vec);
                end
                @(negedge clk);
            end
            ce = 1'b1;
            #1;
            exp_vec = (k < NS) ? (one << k) : '0;
            n_tests++;
            if (save_x_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL save_x sprite %0d: got %h want %h", k, save_x_vec, exp_vec);
            end
            n_tests++;
            if (store_xpos !== spr_x[k]) begin
                n_fail++;
                $display("FAIL store_xpos_scan sprite %0d: got %h want %h", k, store_xpos, spr_x[k]);
            end
            @(negedge clk);
        end
        oam_valid = 1'b0;
        scan_done = 1'b0;
        #1;
        n_tests++;
        if (overflow !== (n_spr > NS)) begin
            n_fail++;
            $display("FAIL overflow_after_scan: got %b want %b", overflow, (n_spr > NS));
        end

        // Distinct X values of allocated sprites, visited newest-first.
        for (int k = 0; k < nalloc; k++) begin
            seen = 1'b0;
            foreach (xs[j]) if (xs[j] == spr_x[k]) seen = 1'b1;
            if (!seen) xs.push_front(spr_x[k]);
        end

        foreach (xs[v]) begin
            rx = xs[v];
            @(negedge clk);
            render_x = rx;
            x_match_vec = '0;
            fetch_q.delete();
            for (int k = 0; k < nalloc; k++) begin
                if (spr_x[k] == rx) begin
                    x_match_vec[k] = 1'b1;
                    fetch_q.push_back(k);
                end
            end
            nf = fetch_q.size();
            wait_cnt = 0;
            ce_idx = 0;
            first_req = -1;
            lo_done = 1'b0;
            for (int c = 0; c < 400 && fetch_q.size() > 0; c++) begin
                cur_ce = ce_alt ? (c % 2 == 1) : 1'b1;
                ce = cur_ce;
                vif.vram_ack = 1'b0;
                if (abort_hi && cur_ce && vif.vram_req === 1'b1 && vif.vram_plane === 1'b1) begin
                    line_start = 1'b1;
                    #1;
                    n_tests++;
                    if (store_reset !== 1'b1) begin
                        n_fail++;
                        $display("FAIL abort_store_reset: got %b want 1", store_reset);
                    end
                    n_tests++;
                    if (tile_save_vec !== '0) begin
                        n_fail++;
                        $display("FAIL abort_tile_save: got %h want 0", tile_save_vec);
                    end
                    @(negedge clk);
                    line_start  = 1'b0;
                    x_match_vec = '0;
                    ce          = 1'b1;
                    oam_valid   = 1'b1;
                    oam_x       = 8'd50;
                    oam_attr    = 5'd0;
                    #1;
                    n_tests++;
                    if (vif.vram_req !== 1'b0) begin
                        n_fail++;
                        $display("FAIL abort_req_drop: got %b want 0", vif.vram_req);
                    end
                    n_tests++;
                    if (tile_save_vec !== '0 || bg_stall !== 1'b0) begin
                        n_fail++;
                        $display("FAIL abort_after: tile_save %h bg_stall %b want 0/0", tile_save_vec, bg_stall);
                    end
                    n_tests++;
                    if (save_x_vec !== one) begin
                        n_fail++;
                        $display("FAIL abort_count_reset: save_x got %h want %h", save_x_vec, one);
                    end
                    @(negedge clk);
                    oam_valid = 1'b0;
                    scan_done = 1'b1;
                    @(negedge clk);
                    scan_done = 1'b0;
                    return;
                end
                if (cur_ce && vif.vram_req === 1'b1) begin
                    if (first_req < 0) first_req = ce_idx;
                    n_tests++;
                    if (vif.vram_slot !== 4'(fetch_q[0]) || vif.vram_plane !== lo_done) begin
                        n_fail++;
                        $display("FAIL vram_req_fields: slot %0d plane %b want %0d/%b",
                                 vif.vram_slot, vif.vram_plane, fetch_q[0], lo_done);
                    end
                    wait_cnt++;
                    if (wait_cnt == lat) begin
                        wait_cnt = 0;
                        vif.vram_ack = 1'b1;
                        if (!lo_done) begin
                            lo_val = fixed_data ? 8'hA5 : 8'($urandom);
                            vif.vram_data = lo_val;
                            lo_done = 1'b1;
                        end else begin
                            hi_val = fixed_data ? 8'h3C : 8'($urandom);
                            vif.vram_data = hi_val;
                        end
                    end
                end
                #1;
                n_tests++;
                if (bg_stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bg_stall_gap x=%0d cycle %0d: got %b want 1", rx, c, bg_stall);
                end
                if (!cur_ce) begin
                    n_tests++;
                    if (tile_save_vec !== '0 || save_x_vec !== '0 || store_reset !== 1'b0) begin
                        n_fail++;
                        $display("FAIL strobe_ce0: tile_save %h save_x %h store_reset %b want 0",
                                 tile_save_vec, save_x_vec, store_reset);
                    end
                end else if (tile_save_vec !== '0) begin
                    s = fetch_q.pop_front();
                    exp_vec = one << s;
                    n_tests++;
                    if (tile_save_vec !== exp_vec || index_o !== 4'(s)) begin
                        n_fail++;
                        $display("FAIL tile_save_slot: vec %h index %0d want %h/%0d",
                                 tile_save_vec, index_o, exp_vec, s);
                    end
                    n_tests++;
                    if (tile0_o !== lo_val || tile1_o !== hi_val) begin
                        n_fail++;
                        $display("FAIL tile_data slot %0d: got %h/%h want %h/%h", s, tile0_o, tile1_o, lo_val, hi_val);
                    end
                    n_tests++;
                    if ({prio_o, pal_o, cgb_pal_o} !== spr_attr[s]) begin
                        n_fail++;
                        $display("FAIL attr slot %0d: got %b want %b", s, {prio_o, pal_o, cgb_pal_o}, spr_attr[s]);
                    end
                    lo_done = 1'b0;
                end
                if (cur_ce) ce_idx++;
                @(negedge clk);
                vif.vram_ack = 1'b0;
            end
            n_tests++;
            if (fetch_q.size() != 0) begin
                n_fail++;
                $display("FAIL fetch_timeout x=%0d: %0d saves missing", rx, fetch_q.size());
                fetch_q.delete();
            end
            n_tests++;
            if (ce_idx != nf * (2 * lat + 2) || first_req != 1) begin
                n_fail++;
                $display("FAIL fetch_timing x=%0d: stall ce-cycles %0d first req %0d want %0d/1",
                         rx, ce_idx, first_req, nf * (2 * lat + 2));
            end
            ce = 1'b1;
            #1;
            n_tests++;
            if (bg_stall !== 1'b0 || vif.vram_req !== 1'b0 || store_xpos !== rx) begin
                n_fail++;
                $display("FAIL render_idle x=%0d: bg_stall %b req %b xpos %h want 0/0/%h",
                         rx, bg_stall, vif.vram_req, store_xpos, rx);
            end
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        ce       = 1'b1;
        render_x = 8'h37;
        quiet_inputs();
        @(negedge clk);
        #1;
        n_tests++;
        if (save_x_vec !== '0 || tile_save_vec !== '0 || store_reset !== 1'b0 ||
            vif.vram_req !== 1'b0 || bg_stall !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: save_x %h tile_save %h sr %b req %b stall %b ovf %b want all 0",
                     save_x_vec, tile_save_vec, store_reset, vif.vram_req, bg_stall, overflow);
        end
        n_tests++;
        if (tile0_o !== 8'h00 || tile1_o !== 8'h00 || index_o !== 4'h0 ||
            {prio_o, pal_o, cgb_pal_o} !== 5'b0 || vif.vram_plane !== 1'b0 || vif.vram_slot !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: t0 %h t1 %h idx %h attr %b plane %b slot %h want 0",
                     tile0_o, tile1_o, index_o, {prio_o, pal_o, cgb_pal_o}, vif.vram_plane, vif.vram_slot);
        end
        n_tests++;
        if (store_xpos !== 8'h37) begin
            n_fail++;
            $display("FAIL reset_xpos: got %h want 37", store_xpos);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_scan_render();
        n_spr = 3;
        spr_x[0] = 8'd8;  spr_x[1] = 8'd20;  spr_x[2] = 8'd20;
        for (int k = 0; k < 3; k++) spr_attr[k] = 5'($urandom);
        run_line(2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_attr_data();
        n_spr = 1;
        spr_x[0] = 8'd33;
        spr_attr[0] = 5'b10101;
        run_line(1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        n_spr = 12;
        for (int k = 0; k < 12; k++) begin
            spr_x[k] = 8'(k * 16 + 3);
            spr_attr[k] = 5'($urandom);
        end
        run_line(1, 1'b0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b want 1", overflow);
        end
    endtask

    task automatic test_abort();
        n_spr = 3;
        spr_x[0] = 8'd40; spr_x[1] = 8'd41; spr_x[2] = 8'd40;
        for (int k = 0; k < 3; k++) spr_attr[k] = 5'($urandom);
        run_line(2, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ce_toggle();
        n_spr = 3;
        spr_x[0] = 8'd8;  spr_x[1] = 8'd20;  spr_x[2] = 8'd20;
        for (int k = 0; k < 3; k++) spr_attr[k] = 5'($urandom);
        run_line(2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            n_spr = $urandom_range(1, 12);
            for (int k = 0; k < n_spr; k++) begin
                spr_x[k] = 8'($urandom_range(30, 35));
                spr_attr[k] = 5'($urandom);
            end
            run_line($urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_scan_render();
        test_attr_data();
        test_overflow();
        test_abort();
        test_ce_toggle();
        test_random();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
